// File: rtl/mem_sys.sv
// Word-addressed RAM, GPIO output register and optional compare timer on a single core bus.
// Define MEM_SYS_TIMER_EN to build the timer (TCOUNT/TCMP/TCTRL, timer_irq).
module mem_sys #(
    parameter int unsigned RAM_WORDS = 64,
    parameter int unsigned GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       adr,
    input  logic [31:0]       writedata,
    input  logic              memwrite,
    output logic [31:0]       readdata,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    localparam logic [31:0] A_GPIO   = 32'h0000_FF00;
    localparam logic [31:0] A_TCOUNT = 32'h0000_FF04;
    localparam logic [31:0] A_TCMP   = 32'h0000_FF08;
    localparam logic [31:0] A_TCTRL  = 32'h0000_FF0C;
    localparam logic [31:0] WORD_MSK = 32'hFFFF_FFFC;

    logic          w_we;
    logic          w_sel_ram;
    logic          w_sel_gpio;
    logic [AW-1:0] w_ram_idx;

    // Writes are dropped while reset is held, including the reset-less RAM.
    assign w_we       = memwrite & ~reset;
    assign w_sel_ram  = (adr[31:AW+2] == '0);
    assign w_sel_gpio = ((adr & WORD_MSK) == A_GPIO);
    assign w_ram_idx  = adr[AW+1:2];

    logic [31:0]       r_ram [RAM_WORDS];
    logic [GPIO_W-1:0] r_gpio;

    always_ff @(posedge clk) begin
        if (w_we && w_sel_ram) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpio <= '0;
        end else if (w_we && w_sel_gpio) begin
            r_gpio <= writedata[GPIO_W-1:0];
        end
    end

    assign gpio_out = r_gpio;

`ifdef MEM_SYS_TIMER_EN
    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } tstate_t;

    tstate_t     r_state;
    tstate_t     w_state_nxt;
    logic [31:0] r_tcount;
    logic [31:0] r_tcmp;
    logic        r_autoreload;
    logic        r_flag;
    logic        r_irqen;
    logic [31:0] w_tcount_nxt;
    logic        w_flag_nxt;
    logic        w_match;
    logic        w_wr_tcount;
    logic        w_wr_tcmp;
    logic        w_wr_tctrl;
    logic [31:0] w_tctrl_rd;

    assign w_wr_tcount = w_we && ((adr & WORD_MSK) == A_TCOUNT);
    assign w_wr_tcmp   = w_we && ((adr & WORD_MSK) == A_TCMP);
    assign w_wr_tctrl  = w_we && ((adr & WORD_MSK) == A_TCTRL);
    assign w_match     = (r_state == T_RUN) && (r_tcount == r_tcmp);

    // Later assignments take priority: software count write beats
    // increment/reload, and a compare match beats write-1-to-clear.
    always_comb begin
        w_state_nxt  = r_state;
        w_tcount_nxt = r_tcount;
        w_flag_nxt   = r_flag;
        if (r_state == T_RUN) begin
            w_tcount_nxt = (w_match && r_autoreload) ? '0 : r_tcount + 32'd1;
        end
        if (w_wr_tcount) begin
            w_tcount_nxt = writedata;
        end
        if (w_wr_tctrl) begin
            w_state_nxt = writedata[0] ? T_RUN : T_IDLE;
            if (writedata[2]) begin
                w_flag_nxt = 1'b0;
            end
        end
        if (w_match) begin
            w_flag_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= T_IDLE;
            r_tcount     <= '0;
            r_tcmp       <= '0;
            r_autoreload <= 1'b0;
            r_flag       <= 1'b0;
            r_irqen      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tcount <= w_tcount_nxt;
            r_flag   <= w_flag_nxt;
            if (w_wr_tcmp) begin
                r_tcmp <= writedata;
            end
            if (w_wr_tctrl) begin
                r_autoreload <= writedata[1];
                r_irqen      <= writedata[3];
            end
        end
    end

    assign w_tctrl_rd = {28'd0, r_irqen, r_flag, r_autoreload, (r_state == T_RUN)};
    assign timer_irq  = r_flag & r_irqen;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        if (w_sel_ram) begin
            readdata = r_ram[w_ram_idx];
        end else if (w_sel_gpio) begin
            readdata = 32'(r_gpio);
        end
`ifdef MEM_SYS_TIMER_EN
        else if ((adr & WORD_MSK) == A_TCOUNT) begin
            readdata = r_tcount;
        end else if ((adr & WORD_MSK) == A_TCMP) begin
            readdata = r_tcmp;
        end else if ((adr & WORD_MSK) == A_TCTRL) begin
            readdata = w_tctrl_rd;
        end
`endif
    end

endmodule

// File: tb/tb_mem_sys.sv
// Self-checking bench for mem_sys: directed vector table, timer/reset sequences, random vs reference model.
// Timer sequences are built only when MEM_SYS_TIMER_EN is defined.
module tb_mem_sys;

    localparam int unsigned RAM_WORDS = 64;
    localparam int unsigned GPIO_W    = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       adr = '0;
    logic [31:0]       writedata = '0;
    logic              memwrite = 1'b0;
    logic [31:0]       readdata;
    logic [GPIO_W-1:0] gpio_out;
    logic              timer_irq;

    mem_sys #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W)) dut (
        .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
        .memwrite(memwrite), .readdata(readdata), .gpio_out(gpio_out),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_ram [RAM_WORDS];
    bit          m_valid [RAM_WORDS];
    logic [31:0] m_gpio, m_cnt, m_cmp;
    bit          m_en, m_ar, m_flag, m_ie;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // 0 RAM, 1 GPIO, 2 TCOUNT, 3 TCMP, 4 TCTRL, 5 unmapped
    function automatic int m_kind(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (a < 32'(4 * RAM_WORDS)) return 0;
        if (w == 32'h0000_FF00) return 1;
`ifdef MEM_SYS_TIMER_EN
        if (w == 32'h0000_FF04) return 2;
        if (w == 32'h0000_FF08) return 3;
        if (w == 32'h0000_FF0C) return 4;
`endif
        return 5;
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        case (m_kind(a))
            0: return m_ram[a / 4];
            1: return m_gpio;
            2: return m_cnt;
            3: return m_cmp;
            4: return {28'd0, m_ie, m_flag, m_ar, m_en};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_known(input logic [31:0] a);
        if (m_kind(a) != 0) return 1'b1;
        return m_valid[a / 4];
    endfunction

    task automatic m_reset();
        m_gpio = 0; m_cnt = 0; m_cmp = 0;
        m_en = 0; m_ar = 0; m_flag = 0; m_ie = 0;
    endtask

    task automatic m_edge(input logic [31:0] a, input logic [31:0] wd, input bit we);
        bit          match;
        logic [31:0] new_cnt;
        if (reset) begin
            m_reset();
            return;
        end
        match   = m_en && (m_cnt == m_cmp);
        new_cnt = m_en ? ((match && m_ar) ? 32'h0 : m_cnt + 1) : m_cnt;
        if (we) begin
            case (m_kind(a))
                0: begin m_ram[a / 4] = wd; m_valid[a / 4] = 1'b1; end
                1: m_gpio = wd & ((32'd1 << GPIO_W) - 1);
                2: new_cnt = wd;
                3: m_cmp = wd;
                4: begin
                    m_en = wd[0]; m_ar = wd[1]; m_ie = wd[3];
                    if (wd[2]) m_flag = 1'b0;
                end
                default: ;
            endcase
        end
        if (match) m_flag = 1'b1;
        m_cnt = new_cnt;
    endtask

    // One bus cycle: optional readdata check before the edge, output checks after it.
    task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input bit we,
                       input bit do_chk, input logic [31:0] exp, input string nm);
        adr = a; writedata = wd; memwrite = we;
        #1;
        if (do_chk) chk({nm, " readdata"}, readdata, exp);
        @(posedge clk);
        m_edge(a, wd, we);
        #1;
        chk({nm, " gpio_out"}, 32'(gpio_out), m_gpio);
        chk({nm, " timer_irq"}, 32'(timer_irq), 32'(m_flag & m_ie));
        memwrite = 1'b0;
    endtask

    task automatic cyc_m(input logic [31:0] a, input logic [31:0] wd, input bit we, input string nm);
        cyc(a, wd, we, m_known(a), m_rd(a), nm);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        cyc(a, 32'h0, 1'b0, 1'b1, exp, nm);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        bit          we;
        bit          do_chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    initial begin
        int n;
        bit seen;
        for (int i = 0; i < int'(RAM_WORDS); i++) m_valid[i] = 1'b0;
        m_reset();

        // Reset state and write-during-reset
        @(posedge clk);
        #1;
        adr = 32'h0000_FF00;
        #1;
        chk("reset readdata gpio", readdata, 32'h0);
        chk("reset gpio_out", 32'(gpio_out), 32'h0);
        chk("reset timer_irq", 32'(timer_irq), 32'h0);
        cyc(32'h0000_FF00, 32'h0000_00FF, 1'b1, 1'b0, 32'h0, "wr_in_reset");
        reset = 1'b0;

        vt.push_back('{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0});
        vt.push_back('{32'h0000_0014, 32'h1234_5678, 1'b1, 1'b0, 32'h0});
        vt.push_back('{32'h0000_0010, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF});
        vt.push_back('{32'h0000_0014, 32'h0, 1'b0, 1'b1, 32'h1234_5678});
        vt.push_back('{32'h0000_0012, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF});
        vt.push_back('{32'h0000_FF00, 32'h0000_00A5, 1'b1, 1'b1, 32'h0});
        vt.push_back('{32'h0000_FF00, 32'h0, 1'b0, 1'b1, 32'h0000_00A5});
        vt.push_back('{32'h0001_0000, 32'h0, 1'b0, 1'b1, 32'h0});
        vt.push_back('{32'h0001_0010, 32'h5555_5555, 1'b1, 1'b1, 32'h0});
        vt.push_back('{32'h0000_0010, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF});
        vt.push_back('{32'h0000_0000, 32'h1111_1111, 1'b1, 1'b0, 32'h0});
        vt.push_back('{32'h0000_0100, 32'h2222_2222, 1'b1, 1'b1, 32'h0});
        vt.push_back('{32'h0000_0000, 32'h0, 1'b0, 1'b1, 32'h1111_1111});
        vt.push_back('{32'h0000_00FC, 32'h3333_3333, 1'b1, 1'b0, 32'h0});
        vt.push_back('{32'h0000_00FC, 32'h0, 1'b0, 1'b1, 32'h3333_3333});
        vt.push_back('{32'h0000_FF10, 32'h0, 1'b0, 1'b1, 32'h0});
        vt.push_back('{32'h0000_FF0C, 32'h0, 1'b0, 1'b1, 32'h0});
        vt.push_back('{32'h0000_FF00, 32'h1234_5600, 1'b1, 1'b1, 32'h0000_00A5});
        vt.push_back('{32'h0000_FF03, 32'h0, 1'b0, 1'b1, 32'h0});
        vt.push_back('{32'h0000_0020, 32'h0000_600D, 1'b1, 1'b0, 32'h0});
        foreach (vt[i]) begin
            cyc(vt[i].a, vt[i].wd, vt[i].we, vt[i].do_chk, vt[i].exp, $sformatf("vec%0d", i));
        end

`ifdef MEM_SYS_TIMER_EN
        // Autoreload compare with interrupt
        cyc_m(32'h0000_FF08, 32'd5, 1'b1, "set_tcmp5");
        cyc_m(32'h0000_FF0C, 32'hB, 1'b1, "tctrl_b");
        n = 0;
        while (!timer_irq && n < 20) begin
            cyc_m(32'h0000_FF04, 32'h0, 1'b0, "run_to_match");
            n++;
        end
        chk("irq_latency_cycles", 32'(n), 32'd6);
        rd(32'h0000_FF04, 32'h0, "tcount_reloaded");
        rd(32'h0000_FF0C, 32'hF, "tctrl_flag_set");
        cyc(32'h0000_FF0C, 32'hF, 1'b1, 1'b0, 32'h0, "w1c_flag");
        chk("irq_cleared", 32'(timer_irq), 32'h0);

        // Wrap, no autoreload, software write on match cycle
        cyc_m(32'h0000_FF0C, 32'h4, 1'b1, "stop");
        cyc_m(32'h0000_FF08, 32'd3, 1'b1, "set_tcmp3");
        cyc_m(32'h0000_FF04, 32'hFFFF_FFFF, 1'b1, "set_tcount_max");
        cyc_m(32'h0000_FF0C, 32'h9, 1'b1, "tctrl_9");
        rd(32'h0000_FF04, 32'hFFFF_FFFF, "pre_wrap");
        rd(32'h0000_FF04, 32'h0, "wrapped");
        cyc_m(32'h0000_FF04, 32'h0, 1'b0, "count_2");
        cyc_m(32'h0000_FF04, 32'h0, 1'b0, "count_3");
        cyc(32'h0000_FF04, 32'h100, 1'b1, 1'b1, 32'd3, "match_cycle");
        chk("flag_on_match", 32'(timer_irq), 32'h1);
        rd(32'h0000_FF04, 32'h100, "sw_write_wins");

        // Flag set beats write-1-to-clear on the same edge
        cyc_m(32'h0000_FF08, 32'h105, 1'b1, "set_tcmp105");
        cyc_m(32'h0000_FF0C, 32'hD, 1'b1, "clear_flag");
        chk("flag_cleared", 32'(timer_irq), 32'h0);
        cyc_m(32'h0000_FF04, 32'h0, 1'b0, "count_104");
        cyc_m(32'h0000_FF04, 32'h0, 1'b0, "count_105");
        cyc(32'h0000_FF0C, 32'hD, 1'b1, 1'b1, 32'h9, "set_vs_clear");
        chk("set_wins", 32'(timer_irq), 32'h1);
`else
        cyc(32'h0000_FF0C, 32'hB, 1'b1, 1'b0, 32'h0, "tctrl_absent_wr");
        rd(32'h0000_FF0C, 32'h0, "tctrl_absent_rd");
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc_m(32'h0000_FF04, 32'h0, 1'b0, "no_timer");
            if (timer_irq !== 1'b0) seen = 1'b1;
        end
        chk("irq_stays_low_100", 32'(seen), 32'h0);
`endif

        // Asynchronous reset mid-count
        cyc_m(32'h0000_FF00, 32'hFF, 1'b1, "gpio_ff");
        cyc_m(32'h0000_FF04, 32'h40, 1'b1, "tcount_40");
        chk("pre_reset_gpio", 32'(gpio_out), 32'hFF);
        adr = 32'h0000_FF04;
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        chk("async_rst gpio_out", 32'(gpio_out), 32'h0);
        chk("async_rst timer_irq", 32'(timer_irq), 32'h0);
        chk("async_rst tcount", readdata, 32'h0);
        cyc(32'h0000_0020, 32'h0000_0BAD, 1'b1, 1'b0, 32'h0, "ram_wr_in_reset");
        cyc(32'h0000_FF00, 32'h77, 1'b1, 1'b0, 32'h0, "gpio_wr_in_reset");
        reset = 1'b0;
        rd(32'h0000_0020, 32'h0000_600D, "ram_survives_reset");
        rd(32'h0000_FF0C, 32'h0, "tctrl_after_reset");
        rd(32'h0000_FF04, 32'h0, "tcount_idle_a");
        rd(32'h0000_FF04, 32'h0, "tcount_idle_b");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int          k;
            logic [31:0] a, wd;
            bit          we;
            k  = $urandom_range(0, 9);
            wd = $urandom();
            case (k)
                0, 1, 2, 3: begin
                    int idx;
                    idx = ($urandom_range(0, 9) == 0) ? int'(RAM_WORDS) - 1 : $urandom_range(0, 7);
                    a = 32'(idx * 4) + 32'($urandom_range(0, 3));
                end
                4: a = 32'h0000_FF00 + 32'($urandom_range(0, 3));
                5: begin a = 32'h0000_FF04; wd = 32'($urandom_range(0, 12)); end
                6: begin a = 32'h0000_FF08; wd = 32'($urandom_range(0, 12)); end
                7: begin a = 32'h0000_FF0C; wd = 32'($urandom_range(0, 15)); end
                8: a = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom())};
                default: a = 32'h0000_FF10 + 32'($urandom_range(0, 59) * 4);
            endcase
            we = 1'($urandom_range(0, 1));
            cyc_m(a, wd, we, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
